serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: loads two parallel operands, feeds an external
// LSB-first serial adder, and returns the parallel sum and carry. Optional
// signed-overflow output is enabled with the SERADD_OVF_EN macro.
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             sa_load,
    output logic             sa_si_1,
    output logic             sa_si_2,
    input  logic             sa_sum,
    input  logic             sa_cy
`ifdef SERADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        sa_load   = 1'b0;
        sa_si_1   = 1'b0;
        sa_si_2   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sa_si_1 = a_q[0];
                sa_si_2 = b_q[0];
                sa_load = (cnt_q == '0);
                res_d   = {sa_sum, res_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cout_d  = sa_cy;
                    // carry into the MSB is recovered from the sum bit and its operands
                    ovf_d   = (sa_sum ^ a_q[0] ^ b_q[0]) ^ sa_cy;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sum  = res_q;
    assign cout = cout_q;
`ifdef SERADD_OVF_EN
    assign ovf  = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=4) with a behavioural
// serial full adder standing in for the external adder.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [3:0] op_a, op_b;
    logic       out_valid, out_ready;
    logic [3:0] sum;
    logic       cout, busy;
    logic       sa_load, sa_si_1, sa_si_2, sa_sum, sa_cy;
`ifdef SERADD_OVF_EN
    logic       ovf;
`endif

    int errors = 0;
    int checks = 0;

    serial_add_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy),
        .sa_load(sa_load), .sa_si_1(sa_si_1), .sa_si_2(sa_si_2),
        .sa_sum(sa_sum), .sa_cy(sa_cy)
`ifdef SERADD_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    // external serial adder: carry register cleared while sa_load is high
    logic cy_q = 1'b0;
    logic c_eff;
    assign c_eff  = sa_load ? 1'b0 : cy_q;
    assign sa_sum = sa_si_1 ^ sa_si_2 ^ c_eff;
    assign sa_cy  = (sa_si_1 & sa_si_2) | (sa_si_1 & c_eff) | (sa_si_2 & c_eff);
    always @(posedge clk) cy_q <= sa_cy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Presents one operation and returns when out_valid is first seen (or the bound expires).
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input bit pulse,
                         output int lat, output logic [3:0] s1, output logic [3:0] s2,
                         output int loads);
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        lat = 0;
        loads = 0;
        s1 = '0;
        s2 = '0;
        @(posedge clk); #1;
        lat = 1;
        in_valid = 1'b0;
        op_a = 4'hf;
        op_b = 4'ha;
        while (!out_valid && lat < 20) begin
            if (sa_load) loads++;
            if (lat <= 4) begin
                s1[lat-1] = sa_si_1;
                s2[lat-1] = sa_si_2;
            end
            in_valid = pulse && (lat == 2);
            if (in_valid) op_a = 4'd9;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
    endtask

    int         lat, loads, got;
    logic [3:0] s1, s2;
    int         acc_t[$];
    logic [3:0] va[3] = '{4'd1, 4'd9, 4'd4};
    logic [3:0] vb[3] = '{4'd2, 4'd8, 4'd4};
    logic [3:0] es[3] = '{4'd3, 4'd1, 4'd8};
    logic       ec[3] = '{1'b0, 1'b1, 1'b0};

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        out_ready = 1'b1;
        #12;
        chk("rst in_ready", in_ready, 1);
        chk("rst busy", busy, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst sum", sum, 0);
        chk("rst cout", cout, 0);
        chk("rst sa_load", sa_load, 0);
        @(negedge clk) rst = 1'b1;

        // 3 + 5, first accept right after reset release
        do_op(4'd3, 4'd5, 1'b0, lat, s1, s2, loads);
        chk("3+5 latency", lat, 5);
        chk("3+5 loads", loads, 1);
        chk("3+5 si_1 bits", s1, 4'b0011);
        chk("3+5 si_2 bits", s2, 4'b0101);
        chk("3+5 sum", sum, 8);
        chk("3+5 cout", cout, 0);
        @(posedge clk); #1;
        chk("3+5 idle in_ready", in_ready, 1);
        chk("3+5 idle out_valid", out_valid, 0);
        chk("3+5 idle sum held", sum, 8);
        chk("idle sa_si_1", sa_si_1, 0);

        do_op(4'd15, 4'd1, 1'b0, lat, s1, s2, loads);
        chk("15+1 sum", sum, 0);
        chk("15+1 cout", cout, 1);
`ifdef SERADD_OVF_EN
        chk("15+1 ovf", ovf, 0);
`endif
        @(posedge clk); #1;
        do_op(4'd7, 4'd1, 1'b0, lat, s1, s2, loads);
        chk("7+1 sum", sum, 8);
        chk("7+1 cout", cout, 0);
`ifdef SERADD_OVF_EN
        chk("7+1 ovf", ovf, 1);
`endif
        @(posedge clk); #1;

        // result held in DONE while out_ready is low
        out_ready = 1'b0;
        do_op(4'd5, 4'd6, 1'b0, lat, s1, s2, loads);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("hold out_valid", out_valid, 1);
            chk("hold sum", sum, 11);
            chk("hold cout", cout, 0);
            chk("hold in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release in_ready", in_ready, 1);
        chk("release out_valid", out_valid, 0);

        // in_valid pulse with op_a=9 during SHIFT is ignored
        do_op(4'd2, 4'd2, 1'b1, lat, s1, s2, loads);
        chk("2+2 pulse latency", lat, 5);
        chk("2+2 pulse sum", sum, 4);
        chk("2+2 pulse cout", cout, 0);
        @(posedge clk); #1;

        // reset asserted at cnt==2
        in_valid = 1'b1;
        op_a = 4'd13;
        op_b = 4'd11;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre-reset busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("mid rst busy", busy, 0);
        chk("mid rst in_ready", in_ready, 1);
        chk("mid rst out_valid", out_valid, 0);
        chk("mid rst sum", sum, 0);
        chk("mid rst cout", cout, 0);
        chk("mid rst sa_si_1", sa_si_1, 0);
        chk("mid rst sa_si_2", sa_si_2, 0);
        #2 rst = 1'b1;
        do_op(4'd6, 4'd6, 1'b0, lat, s1, s2, loads);
        chk("6+6 latency", lat, 5);
        chk("6+6 sum", sum, 12);
        chk("6+6 cout", cout, 0);
        @(posedge clk); #1;

        // back-to-back with in_valid held high
        got = 0;
        in_valid = 1'b1;
        op_a = va[0];
        op_b = vb[0];
        for (int cyc = 0; cyc < 24; cyc++) begin
            automatic bit acc = in_ready && in_valid;
            @(posedge clk); #1;
            if (acc) begin
                acc_t.push_back(cyc);
                if (acc_t.size() < 3) begin
                    op_a = va[acc_t.size()];
                    op_b = vb[acc_t.size()];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid && got < 3) begin
                chk("b2b sum", sum, es[got]);
                chk("b2b cout", cout, ec[got]);
                got++;
            end
        end
        chk("b2b results", got, 3);
        chk("b2b accepts", acc_t.size(), 3);
        if (acc_t.size() == 3) begin
            chk("b2b spacing 1", acc_t[1] - acc_t[0], 6);
            chk("b2b spacing 2", acc_t[2] - acc_t[1], 6);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
